// File: rtl/sram2rw_fifo_ctrl.sv
// Ready/valid FIFO built on a 2-port SRAM macro (port 1 writes, port 2 reads).
// A 2-entry output buffer hides the macro's registered read latency.
module sram2rw_fifo_ctrl #(
    parameter int WIDTH  = 16,
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enq_valid,
    output logic              enq_ready,
    input  logic [WIDTH-1:0]  enq_bits,
    output logic              deq_valid,
    input  logic              deq_ready,
    output logic [WIDTH-1:0]  deq_bits,
    output logic [ADDR_W:0]   count,
    output logic [ADDR_W-1:0] sram_a1,
    output logic              sram_csb1,
    output logic              sram_web1,
    output logic              sram_oeb1,
    output logic [WIDTH-1:0]  sram_i1,
    output logic [ADDR_W-1:0] sram_a2,
    output logic              sram_csb2,
    output logic              sram_web2,
    output logic              sram_oeb2,
    output logic [WIDTH-1:0]  sram_i2,
    input  logic [WIDTH-1:0]  sram_o2
);

    localparam int CNT_W = ADDR_W + 1;

    logic [ADDR_W-1:0] wptr, rptr;
    logic [CNT_W-1:0]  sram_cnt;
    logic              inflight;
    logic [1:0]        obuf_cnt;
    logic [WIDTH-1:0]  obuf_head, obuf_tail;
    logic              wfire, rfire, dfire;
    logic [2:0]        obuf_occ;

    assign enq_ready = !reset && (sram_cnt < CNT_W'(DEPTH));
    assign wfire     = enq_valid && enq_ready;
    assign deq_valid = !reset && (obuf_cnt != 2'd0);
    assign dfire     = deq_valid && deq_ready;

    // Slots the output buffer will need after this edge; issue a read only if one stays free.
    assign obuf_occ  = {1'b0, obuf_cnt} + {2'b00, inflight} - {2'b00, dfire};
    assign rfire     = !reset && (sram_cnt != '0) && (obuf_occ < 3'd2);

    assign count     = sram_cnt + CNT_W'(inflight) + CNT_W'(obuf_cnt);
    assign deq_bits  = obuf_head;

    assign sram_a1   = wptr;
    assign sram_csb1 = !wfire;
    assign sram_web1 = !wfire;
    assign sram_oeb1 = 1'b1;
    assign sram_i1   = enq_bits;

    assign sram_a2   = rptr;
    assign sram_csb2 = !rfire;
    assign sram_web2 = 1'b1;
    assign sram_oeb2 = !rfire;
    assign sram_i2   = '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr      <= '0;
            rptr      <= '0;
            sram_cnt  <= '0;
            inflight  <= 1'b0;
            obuf_cnt  <= 2'd0;
            obuf_head <= '0;
            obuf_tail <= '0;
        end else begin
            if (wfire) wptr <= wptr + 1'b1;
            if (rfire) rptr <= rptr + 1'b1;
            sram_cnt <= sram_cnt + CNT_W'(wfire) - CNT_W'(rfire);
            inflight <= rfire;
            case ({inflight, dfire})
                2'b10: begin
                    if (obuf_cnt == 2'd0) obuf_head <= sram_o2;
                    else                  obuf_tail <= sram_o2;
                    obuf_cnt <= obuf_cnt + 2'd1;
                end
                2'b01: begin
                    obuf_head <= obuf_tail;
                    obuf_cnt  <= obuf_cnt - 2'd1;
                end
                2'b11: begin
                    // Pop and push together: order preserved, occupancy unchanged.
                    if (obuf_cnt == 2'd1) begin
                        obuf_head <= sram_o2;
                    end else begin
                        obuf_head <= obuf_tail;
                        obuf_tail <= sram_o2;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram2rw_fifo_ctrl.sv
// Bench for sram2rw_fifo_ctrl: behavioural SRAM macro, queue scoreboard,
// a cycle table for single-word latency and directed fill/stream/reset sequences.
module tb_sram2rw_fifo_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        enq_valid, enq_ready;
    logic [15:0] enq_bits;
    logic        deq_valid, deq_ready;
    logic [15:0] deq_bits;
    logic [5:0]  count;
    logic [4:0]  sram_a1, sram_a2;
    logic        sram_csb1, sram_web1, sram_oeb1;
    logic        sram_csb2, sram_web2, sram_oeb2;
    logic [15:0] sram_i1, sram_i2, sram_o2;

    logic [15:0] mem [32];
    logic [15:0] exp_q [$];
    int          n_checks = 0;
    int          n_pass   = 0;

    typedef struct {
        logic        ev;
        logic        dr;
        logic [15:0] d;
        logic        rdy;
        logic        dv;
        logic [5:0]  cnt;
        logic        csb1;
        logic        csb2;
        logic        chk_db;
        logic [15:0] db;
    } vec_t;
    vec_t tbl [5];

    sram2rw_fifo_ctrl #(.WIDTH(16), .DEPTH(32), .ADDR_W(5)) dut (
        .clock(clock), .reset(reset),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_bits(enq_bits),
        .deq_valid(deq_valid), .deq_ready(deq_ready), .deq_bits(deq_bits),
        .count(count),
        .sram_a1(sram_a1), .sram_csb1(sram_csb1), .sram_web1(sram_web1),
        .sram_oeb1(sram_oeb1), .sram_i1(sram_i1),
        .sram_a2(sram_a2), .sram_csb2(sram_csb2), .sram_web2(sram_web2),
        .sram_oeb2(sram_oeb2), .sram_i2(sram_i2), .sram_o2(sram_o2)
    );

    always #5 clock = ~clock;

    // Macro model: synchronous write on port 1, registered read on port 2.
    always @(posedge clock) begin
        if (!sram_csb1 && !sram_web1) mem[sram_a1] <= sram_i1;
        if (!sram_csb2 && !sram_oeb2) sram_o2 <= mem[sram_a2];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Scoreboard: words accepted are queued, dequeued words must match in order.
    always @(negedge clock) begin
        if (reset) begin
            exp_q.delete();
        end else begin
            chk("count_model", 32'(count), exp_q.size());
            if (!sram_csb1 && !sram_csb2) chk("addr_clash", 32'(sram_a1 != sram_a2), 1);
            if (deq_valid && deq_ready) begin
                if (exp_q.size() == 0) chk("deq_extra", 32'(exp_q.size()), 1);
                else                   chk("deq_data", 32'(deq_bits), 32'(exp_q.pop_front()));
            end
            if (enq_valid && enq_ready) exp_q.push_back(enq_bits);
        end
    end

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int n);
        reset = 1'b1; enq_valid = 1'b0; deq_ready = 1'b0; enq_bits = '0;
        repeat (n) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    initial begin
        int next, acc, first_block, gaps, deqs, first_deq, last_deq, c;
        logic fire;

        tbl[0] = '{1'b1, 1'b1, 16'hA5A5, 1'b1, 1'b0, 6'd0, 1'b0, 1'b1, 1'b0, 16'h0};
        tbl[1] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 6'd1, 1'b1, 1'b0, 1'b0, 16'h0};
        tbl[2] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 6'd1, 1'b1, 1'b1, 1'b0, 16'h0};
        tbl[3] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b1, 6'd1, 1'b1, 1'b1, 1'b1, 16'hA5A5};
        tbl[4] = '{1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 6'd0, 1'b1, 1'b1, 1'b0, 16'h0};

        // Reset state
        reset = 1'b1; enq_valid = 1'b0; deq_ready = 1'b0; enq_bits = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_enq_ready", 32'(enq_ready), 0);
        chk("rst_deq_valid", 32'(deq_valid), 0);
        chk("rst_csb1", 32'(sram_csb1), 1);
        chk("rst_csb2", 32'(sram_csb2), 1);
        chk("rst_web1", 32'(sram_web1), 1);
        chk("rst_oeb2", 32'(sram_oeb2), 1);
        @(posedge clock); #1 reset = 1'b0;
        @(negedge clock);
        chk("rst_count", 32'(count), 0);
        chk("rst_deq_bits", 32'(deq_bits), 0);
        chk("rst_a1", 32'(sram_a1), 0);
        chk("rst_a2", 32'(sram_a2), 0);
        chk("tie_oeb1", 32'(sram_oeb1), 1);
        chk("tie_web2", 32'(sram_web2), 1);
        chk("tie_i2", 32'(sram_i2), 0);
        next_cycle();

        // Single word latency table
        for (int i = 0; i < 5; i++) begin
            enq_valid = tbl[i].ev; deq_ready = tbl[i].dr; enq_bits = tbl[i].d;
            @(negedge clock);
            chk($sformatf("t%0d_enq_ready", i), 32'(enq_ready), 32'(tbl[i].rdy));
            chk($sformatf("t%0d_deq_valid", i), 32'(deq_valid), 32'(tbl[i].dv));
            chk($sformatf("t%0d_count", i), 32'(count), 32'(tbl[i].cnt));
            chk($sformatf("t%0d_csb1", i), 32'(sram_csb1), 32'(tbl[i].csb1));
            chk($sformatf("t%0d_csb2", i), 32'(sram_csb2), 32'(tbl[i].csb2));
            if (tbl[i].chk_db) chk($sformatf("t%0d_deq_bits", i), 32'(deq_bits), 32'(tbl[i].db));
            next_cycle();
        end

        // Fill with consumer stalled
        do_reset(1);
        next = 0; acc = 0; first_block = -1;
        for (int i = 0; i < 40; i++) begin
            enq_valid = 1'b1; enq_bits = 16'(next);
            @(negedge clock);
            fire = enq_ready;
            if (!enq_ready && first_block < 0) first_block = i;
            if (!enq_ready) chk("full_csb1", 32'(sram_csb1), 1);
            next_cycle();
            if (fire) begin acc++; next++; end
        end
        chk("fill_accepted", acc, 34);
        chk("fill_first_block", first_block, 34);
        @(negedge clock);
        chk("full_count", 32'(count), 34);
        chk("full_enq_ready", 32'(enq_ready), 0);
        next_cycle();

        // Drain from full while producer keeps pushing
        deq_ready = 1'b1; enq_valid = 1'b1; enq_bits = 16'(next);
        @(negedge clock);
        chk("first_pop_enq_ready", 32'(enq_ready), 0);
        chk("first_pop_valid", 32'(deq_valid), 1);
        chk("first_pop_data", 32'(deq_bits), 0);
        next_cycle();
        gaps = 0;
        for (int i = 0; i < 50; i++) begin
            enq_bits = 16'(next);
            @(negedge clock);
            if (i == 0) chk("enq_ready_reassert", 32'(enq_ready), 1);
            if (!deq_valid) gaps++;
            fire = enq_ready;
            next_cycle();
            if (fire) next++;
        end
        chk("drain_gaps", gaps, 0);

        // 100-word stream from empty
        do_reset(1);
        next = 0; deqs = 0; first_deq = -1; last_deq = -1;
        for (int i = 0; i < 110; i++) begin
            enq_valid = (next < 100); enq_bits = 16'(next); deq_ready = 1'b1;
            @(negedge clock);
            fire = enq_valid && enq_ready;
            if (deq_valid) begin
                if (first_deq < 0) first_deq = i;
                last_deq = i;
                deqs++;
            end
            next_cycle();
            if (fire) next++;
        end
        chk("stream_first_deq", first_deq, 3);
        chk("stream_deqs", deqs, 100);
        chk("stream_no_bubble", last_deq - first_deq, 99);

        // Random traffic, then drain
        for (int i = 0; i < 2000; i++) begin
            enq_valid = 1'($urandom_range(0, 1));
            deq_ready = 1'($urandom_range(0, 1));
            enq_bits  = 16'($urandom);
            @(negedge clock);
            next_cycle();
        end
        enq_valid = 1'b0; deq_ready = 1'b1;
        c = 0;
        @(negedge clock);
        while (count != 0 && c < 100) begin
            @(negedge clock);
            c++;
        end
        chk("rand_drain_count", 32'(count), 0);
        chk("rand_sb_empty", exp_q.size(), 0);
        next_cycle();

        // Reset while a read is in flight
        do_reset(1);
        acc = 0; c = 0;
        while (acc < 21 && c < 40) begin
            enq_valid = 1'b1; enq_bits = 16'(16'h0100 + acc); deq_ready = 1'b0;
            @(negedge clock);
            fire = enq_ready;
            next_cycle();
            if (fire) acc++;
            c++;
        end
        chk("mid_fill_acc", acc, 21);
        enq_valid = 1'b0;
        repeat (4) next_cycle();
        deq_ready = 1'b1;
        @(negedge clock);
        chk("mid_pop_valid", 32'(deq_valid), 1);
        chk("mid_read_issue", 32'(sram_csb2), 0);
        next_cycle();
        deq_ready = 1'b0; reset = 1'b1;
        @(negedge clock);
        chk("mid_count_pre", 32'(count), 20);
        chk("mid_rst_enq_ready", 32'(enq_ready), 0);
        chk("mid_rst_deq_valid", 32'(deq_valid), 0);
        next_cycle();
        reset = 1'b0;
        @(negedge clock);
        chk("post_rst_count", 32'(count), 0);
        chk("post_rst_deq_valid", 32'(deq_valid), 0);
        enq_valid = 1'b1; enq_bits = 16'h1234; deq_ready = 1'b1;
        next_cycle();
        enq_valid = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clock);
            if (i < 3) chk($sformatf("post_rst_c%0d_valid", i), 32'(deq_valid), 0);
            if (i == 3) begin
                chk("post_rst_c3_valid", 32'(deq_valid), 1);
                chk("post_rst_c3_data", 32'(deq_bits), 32'h1234);
            end
            if (i == 4) chk("post_rst_c4_count", 32'(count), 0);
            next_cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sram2rw_fifo_ctrl.md
Name: sram2rw_fifo_ctrl

Overview:
- Controller that turns one 32x16 dual-port SRAM macro into a ready/valid FIFO.
- Port 1 is used for writes only; port 2 is used for reads only.
- A 2-entry output buffer absorbs the macro's 1-cycle registered read latency and sustains 1 word/cycle.
- Sits between a producer and a consumer in the cache/buffer datapath; the macro is instantiated beside it and clocked by the same clock on CE1/CE2.

Parameters:
- WIDTH, 16, data width; must equal the macro word width.
- DEPTH, 32, SRAM entries; power of two.
- ADDR_W, 5, log2(DEPTH); must equal the macro address width.

Ports:
- clock  in  1  block clock; also drives macro CE1/CE2.
- reset  in  1  synchronous, active-high reset.
- enq_valid  in  1  producer has a word.
- enq_ready  out  1  controller accepts a word this cycle.
- enq_bits  in  WIDTH  write data.
- deq_valid  out  1  head word available.
- deq_ready  in  1  consumer takes the head word.
- deq_bits  out  WIDTH  head word.
- count  out  ADDR_W+1  total words held (SRAM + in-flight + output buffer).
- sram_a1  out  ADDR_W  port-1 address (write pointer).
- sram_csb1  out  1  port-1 chip select, active low.
- sram_web1  out  1  port-1 write enable, active low.
- sram_oeb1  out  1  port-1 output enable, active low; tied 1.
- sram_i1  out  WIDTH  port-1 write data.
- sram_a2  out  ADDR_W  port-2 address (read pointer).
- sram_csb2  out  1  port-2 chip select, active low.
- sram_web2  out  1  port-2 write enable, active low; tied 1.
- sram_oeb2  out  1  port-2 output enable, active low.
- sram_i2  out  WIDTH  port-2 write data; tied 0.
- sram_o2  in  WIDTH  port-2 read data; registered in the macro and valid the cycle after a read.

Behaviour:
- Clocking and reset: one clock, `clock`. Reset is synchronous and active-high, on `reset`.
- Reset state:
  - wptr, rptr, sram_cnt, inflight and obuf_cnt are all 0.
  - enq_ready=0 and deq_valid=0 while reset is high.
  - deq_bits=0 after reset.
  - sram_csb1/csb2/web1/oeb2 are 1; sram_a1/a2 are 0.
  - SRAM contents are not cleared.
  - Reset asserted mid-operation discards every held and in-flight word. O2 data arriving in the cycle after reset is ignored.
- Write side (combinational outputs, sampled by the macro at the clock edge):
  - enq_ready = !reset && sram_cnt < DEPTH.
  - wfire = enq_valid && enq_ready.
  - sram_csb1 = sram_web1 = !wfire; sram_a1 = wptr; sram_i1 = enq_bits.
  - On wfire, wptr increments and wraps DEPTH-1 -> 0.
- Read issue:
  - rfire = !reset && sram_cnt != 0 && (obuf_cnt + inflight - dfire) < 2, where dfire = deq_valid && deq_ready.
  - sram_csb2 = sram_oeb2 = !rfire; sram_a2 = rptr.
  - On rfire, rptr wraps like wptr; inflight is set to 1 for the next cycle, otherwise 0.
- SRAM occupancy: sram_cnt += wfire - rfire, so a simultaneous write and read leaves it unchanged.
- Same-address hazard: a word becomes readable only in the cycle after its write edge, because sram_cnt counts committed writes only. A port-1 write and a port-2 read therefore never target the same address on the same edge.
- Return path: when inflight=1, sram_o2 is pushed into obuf (2-entry FIFO) at the end of that cycle.
- Dequeue: deq_valid = obuf_cnt != 0; deq_bits = obuf head. A pop and a push in the same cycle keep the order and leave obuf_cnt unchanged.
- count = sram_cnt + inflight + obuf_cnt. Maximum is DEPTH+2 = 34.
- Latency: enq fire in cycle 0 into an empty FIFO gives read issue in cycle 1, O2 valid in cycle 2, and deq_valid=1 in cycle 3.
- Throughput: with enq_valid and deq_ready held high, 1 word/cycle is sustained after fill, with no bubbles.
- Full condition: enq_ready drops only when sram_cnt == DEPTH (total count 34 with the output buffer full and the consumer stalled).
- Empty: deq_valid=0 and no read is issued. The ports stay deselected (CSB=1) on idle cycles for power.
- Ordering: strict FIFO across pointer wrap.

Test Plan:
- Reset, then a single enq of 0xA5A5 in cycle 0 with deq_ready=1 -> deq_valid=1 with deq_bits=0xA5A5 in cycle 3; count returns to 0 the cycle after the pop.
- deq_ready=0, enq 40 words 0x0000..0x0027 back-to-back -> 34 words accepted; enq_ready=0 from the 35th attempt; count=34; sram_csb1 stays 1 while full.
- From full, deq_ready=1 with enq continuing -> words are output in order 0x0000.. with no gaps; enq_ready re-asserts 1 cycle after the first pop frees SRAM space.
- Stream 100 words with enq_valid=deq_ready=1 -> 1 word/cycle after the 3-cycle fill; pointers wrap past 31; data matches an incrementing pattern; a 0x0000..0x0063 scoreboard passes.
- Random enq_valid/deq_ready at 50% for 2000 cycles -> no loss, duplication or reorder; csb1 and csb2 never both select the same address on one edge; count matches the model.
- Assert reset for 1 cycle while count=20 and a read is in flight -> next cycle count=0, deq_valid=0; a new word 0x1234 emerges 3 cycles after its enq, not stale data.
